// File: rtl/perf_event_counter_unit.sv
// Performance event counters with snapshot/readback channel for a debug host.
// Optional macro PERF_WRAP_EN: counters wrap modulo 2^WIDTH instead of saturating.
module perf_event_counter_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clkFPGA,
  input  logic             rst,
  input  logic             enable,
  input  logic             finish,
  input  logic             ev_stall,
  input  logic             ev_arith,
  input  logic             ev_mem,
  input  logic             ev_retire,
  input  logic             clear,
  input  logic             snap_req,
  output logic             snap_ack,
  input  logic [2:0]       rd_sel,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] stall_count,
  output logic [WIDTH-1:0] arith_count,
  output logic [WIDTH-1:0] mem_count,
  output logic [WIDTH-1:0] cycle_count,
  output logic [WIDTH-1:0] instr_count,
  output logic [4:0]       overflow
);

  localparam int unsigned NumCnt = 5;
  localparam logic [WIDTH-1:0] CntMax = '1;
  localparam logic [WIDTH-1:0] CntOne = WIDTH'(1);

  typedef enum logic [1:0] {StIdle, StRun, StFrozen} state_e;

  state_e            state_q, state_d;
  logic              count_en;
  logic [NumCnt-1:0] ev_vec;
  logic [NumCnt-1:0] ovf_q, ovf_d;
  logic [WIDTH-1:0]  cnt_q [NumCnt];
  logic [WIDTH-1:0]  cnt_d [NumCnt];
  logic [WIDTH-1:0]  shadow_q [NumCnt];
  logic [WIDTH-1:0]  rd_data_d;
  logic              snap_ack_q;
  logic              capture;

  // Counter index order matches rd_sel; the cycle counter's strobe is always high.
  assign ev_vec  = {ev_retire, 1'b1, ev_mem, ev_arith, ev_stall};
  assign capture = snap_req && !snap_ack_q;

  always_comb begin
    state_d  = state_q;
    count_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (enable && !finish) begin
          state_d  = StRun;
          count_en = 1'b1;
        end
      end
      StRun: begin
        count_en = enable;
        if (finish) state_d = StFrozen;
      end
      StFrozen: begin
        if (clear) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    for (int i = 0; i < NumCnt; i++) begin
      cnt_d[i] = cnt_q[i];
      ovf_d[i] = ovf_q[i];
      if (clear) begin
        cnt_d[i] = '0;
        ovf_d[i] = 1'b0;
      end else if (count_en && ev_vec[i]) begin
        if (cnt_q[i] == CntMax) ovf_d[i] = 1'b1;
`ifdef PERF_WRAP_EN
        cnt_d[i] = cnt_q[i] + CntOne;
`else
        if (cnt_q[i] != CntMax) cnt_d[i] = cnt_q[i] + CntOne;
`endif
      end
    end
  end

  always_comb begin
    rd_data_d = '0;
    case (rd_sel)
      3'd0:    rd_data_d = shadow_q[0];
      3'd1:    rd_data_d = shadow_q[1];
      3'd2:    rd_data_d = shadow_q[2];
      3'd3:    rd_data_d = shadow_q[3];
      3'd4:    rd_data_d = shadow_q[4];
      default: rd_data_d = '0;
    endcase
  end

  always_ff @(posedge clkFPGA) begin
    if (rst) begin
      state_q    <= StIdle;
      ovf_q      <= '0;
      snap_ack_q <= 1'b0;
      rd_data    <= '0;
      for (int i = 0; i < NumCnt; i++) begin
        cnt_q[i]    <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ovf_q      <= ovf_d;
      snap_ack_q <= snap_req;
      rd_data    <= rd_data_d;
      for (int i = 0; i < NumCnt; i++) begin
        cnt_q[i] <= cnt_d[i];
        // Shadows take this edge's pre-increment (and pre-clear) live values.
        if (capture) shadow_q[i] <= cnt_q[i];
      end
    end
  end

  assign snap_ack    = snap_ack_q;
  assign overflow    = ovf_q;
  assign stall_count = cnt_q[0];
  assign arith_count = cnt_q[1];
  assign mem_count   = cnt_q[2];
  assign cycle_count = cnt_q[3];
  assign instr_count = cnt_q[4];

endmodule

// File: tb/tb_perf_event_counter_unit.sv
// Self-checking bench for perf_event_counter_unit (WIDTH=32 main instance, WIDTH=4 saturation instance).
module tb_perf_event_counter_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, enable, finish, ev_stall, ev_arith, ev_mem, ev_retire, clear, snap_req;
  logic        snap_ack;
  logic [2:0]  rd_sel;
  logic [31:0] rd_data, stall_count, arith_count, mem_count, cycle_count, instr_count;
  logic [4:0]  overflow;

  logic        w_rst, w_enable, w_ev_stall, w_clear, w_snap_ack;
  logic [3:0]  w_rd_data, w_stall, w_arith, w_mem, w_cycle, w_instr;
  logic [4:0]  w_overflow;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  perf_event_counter_unit #(.WIDTH(32)) dut (
    .clkFPGA(clk), .rst(rst), .enable(enable), .finish(finish),
    .ev_stall(ev_stall), .ev_arith(ev_arith), .ev_mem(ev_mem), .ev_retire(ev_retire),
    .clear(clear), .snap_req(snap_req), .snap_ack(snap_ack), .rd_sel(rd_sel),
    .rd_data(rd_data), .stall_count(stall_count), .arith_count(arith_count),
    .mem_count(mem_count), .cycle_count(cycle_count), .instr_count(instr_count),
    .overflow(overflow)
  );

  perf_event_counter_unit #(.WIDTH(4)) dut4 (
    .clkFPGA(clk), .rst(w_rst), .enable(w_enable), .finish(1'b0),
    .ev_stall(w_ev_stall), .ev_arith(1'b0), .ev_mem(1'b0), .ev_retire(1'b0),
    .clear(w_clear), .snap_req(1'b0), .snap_ack(w_snap_ack), .rd_sel(3'd0),
    .rd_data(w_rd_data), .stall_count(w_stall), .arith_count(w_arith),
    .mem_count(w_mem), .cycle_count(w_cycle), .instr_count(w_instr),
    .overflow(w_overflow)
  );

  function automatic logic [31:0] live(input int i);
    case (i)
      0:       return stall_count;
      1:       return arith_count;
      2:       return mem_count;
      3:       return cycle_count;
      default: return instr_count;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    enable = 0; finish = 0; ev_stall = 0; ev_arith = 0; ev_mem = 0; ev_retire = 0;
    clear = 0; snap_req = 0; rd_sel = 3'd0;
  endtask

  task automatic test_reset();
    quiet();
    enable = 1; ev_stall = 1; snap_req = 1; rst = 1;
    step(); step();
    rst = 0;
    quiet();
    for (int i = 0; i < 5; i++) exp_q.push_back(32'd0);
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (live(i) !== exp_v) begin
        errors++;
        $display("FAIL reset_cnt%0d got=%0d exp=%0d", i, live(i), exp_v);
      end
    end
    checks++;
    if (snap_ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", snap_ack); end
    checks++;
    if (overflow !== 5'd0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", overflow); end
    checks++;
    if (rd_data !== 32'd0) begin errors++; $display("FAIL reset_rd got=%0d exp=0", rd_data); end
  endtask

  task automatic test_count();
    for (int c = 1; c <= 10; c++) begin
      enable = 1; ev_retire = 1; ev_mem = (c == 3 || c == 7);
      step();
      if (c == 1) begin
        checks++;
        if (cycle_count !== 32'd1) begin
          errors++; $display("FAIL first_cycle got=%0d exp=1", cycle_count);
        end
      end
    end
    quiet();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd2);
    exp_q.push_back(32'd10); exp_q.push_back(32'd10);
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (live(i) !== exp_v) begin
        errors++; $display("FAIL count_cnt%0d got=%0d exp=%0d", i, live(i), exp_v);
      end
    end
  endtask

  task automatic test_enable_low();
    for (int c = 0; c < 5; c++) begin
      enable = 0; ev_stall = 1;
      step();
    end
    quiet();
    exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd2);
    exp_q.push_back(32'd10); exp_q.push_back(32'd10);
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (live(i) !== exp_v) begin
        errors++; $display("FAIL hold_cnt%0d got=%0d exp=%0d", i, live(i), exp_v);
      end
    end
  endtask

  task automatic test_finish();
    // Clear in RUN with events present: clear wins, FSM keeps running.
    enable = 1; clear = 1; ev_arith = 1; ev_retire = 1;
    step();
    quiet();
    checks++;
    if (arith_count !== 32'd0 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL run_clear got=%0d/%0d exp=0/0", arith_count, cycle_count);
    end
    // Four enabled cycles, the fourth carrying finish; all four count.
    for (int c = 1; c <= 4; c++) begin
      enable = 1; ev_arith = 1; finish = (c == 4);
      step();
    end
    for (int c = 0; c < 5; c++) begin
      enable = 1; finish = 0; ev_stall = 1; ev_arith = 1; ev_mem = 1; ev_retire = 1;
      step();
    end
    quiet();
    exp_q.push_back(32'd0); exp_q.push_back(32'd4); exp_q.push_back(32'd0);
    exp_q.push_back(32'd4); exp_q.push_back(32'd0);
    for (int i = 0; i < 5; i++) begin
      exp_v = exp_q.pop_front();
      checks++;
      if (live(i) !== exp_v) begin
        errors++; $display("FAIL frozen_cnt%0d got=%0d exp=%0d", i, live(i), exp_v);
      end
    end
    clear = 1;
    step();
    quiet();
    checks++;
    if (arith_count !== 32'd0 || cycle_count !== 32'd0) begin
      errors++; $display("FAIL frozen_clear got=%0d/%0d exp=0/0", arith_count, cycle_count);
    end
    // Back in IDLE, one enabled cycle should start counting again.
    enable = 1;
    step();
    quiet();
    checks++;
    if (cycle_count !== 32'd1) begin
      errors++; $display("FAIL idle_restart got=%0d exp=1", cycle_count);
    end
  endtask

  task automatic test_snapshot();
    enable = 1; clear = 1;
    step();
    clear = 0;
    for (int c = 0; c < 20; c++) step();
    snap_req = 1; rd_sel = 3'd3;
    exp_q.push_back(32'd20);
    step();
    checks++;
    if (snap_ack !== 1'b1) begin errors++; $display("FAIL snap_ack_rise got=%b exp=1", snap_ack); end
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_data !== exp_v) begin errors++; $display("FAIL snap_rd got=%0d exp=%0d", rd_data, exp_v); end
    checks++;
    if (cycle_count !== 32'd22) begin
      errors++; $display("FAIL snap_live got=%0d exp=22", cycle_count);
    end
    step(); step();
    checks++;
    if (snap_ack !== 1'b1 || rd_data !== 32'd20) begin
      errors++; $display("FAIL snap_hold got=%b/%0d exp=1/20", snap_ack, rd_data);
    end
    snap_req = 0;
    step();
    checks++;
    if (snap_ack !== 1'b0) begin errors++; $display("FAIL snap_ack_fall got=%b exp=0", snap_ack); end
    rd_sel = 3'd5;
    step();
    checks++;
    if (rd_data !== 32'd0) begin errors++; $display("FAIL rd_sel5 got=%0d exp=0", rd_data); end
    rd_sel = 3'd3;
    step();
    checks++;
    if (rd_data !== 32'd20) begin errors++; $display("FAIL shadow_keep got=%0d exp=20", rd_data); end
    quiet();
  endtask

  task automatic test_rst_handshake();
    enable = 1; snap_req = 1; rd_sel = 3'd3;
    step();
    checks++;
    if (snap_ack !== 1'b1) begin errors++; $display("FAIL hs_ack got=%b exp=1", snap_ack); end
    rst = 1;
    step();
    rst = 0;
    quiet();
    checks++;
    if (snap_ack !== 1'b0 || rd_data !== 32'd0 || cycle_count !== 32'd0) begin
      errors++;
      $display("FAIL hs_rst got=%b/%0d/%0d exp=0/0/0", snap_ack, rd_data, cycle_count);
    end
  endtask

  task automatic test_clear_capture();
    for (int c = 0; c < 7; c++) begin
      enable = 1;
      step();
    end
    snap_req = 1; clear = 1; rd_sel = 3'd3;
    exp_q.push_back(32'd7);
    step();
    clear = 0; enable = 0;
    step();
    exp_v = exp_q.pop_front();
    checks++;
    if (rd_data !== exp_v) begin errors++; $display("FAIL cc_shadow got=%0d exp=%0d", rd_data, exp_v); end
    checks++;
    if (cycle_count !== 32'd0) begin errors++; $display("FAIL cc_live got=%0d exp=0", cycle_count); end
    quiet();
    step();
  endtask

  task automatic test_width();
    logic [3:0] exp_s;
    w_rst = 1; w_enable = 0; w_ev_stall = 0; w_clear = 0;
    step();
    w_rst = 0;
    for (int c = 1; c <= 17; c++) begin
      w_enable = 1; w_ev_stall = 1;
      step();
      if (c == 15) begin
        checks++;
        if (w_stall !== 4'd15 || w_overflow[0] !== 1'b0) begin
          errors++; $display("FAIL w15 got=%0d/%b exp=15/0", w_stall, w_overflow[0]);
        end
      end
    end
    w_enable = 0; w_ev_stall = 0;
`ifdef PERF_WRAP_EN
    exp_s = 4'd1;
`else
    exp_s = 4'd15;
`endif
    checks++;
    if (w_stall !== exp_s) begin errors++; $display("FAIL w17 got=%0d exp=%0d", w_stall, exp_s); end
    checks++;
    if (w_overflow[0] !== 1'b1) begin
      errors++; $display("FAIL w_ovf got=%b exp=1", w_overflow[0]);
    end
    w_clear = 1;
    step();
    w_clear = 0;
    checks++;
    if (w_overflow !== 5'd0 || w_stall !== 4'd0) begin
      errors++; $display("FAIL w_clear got=%b/%0d exp=0/0", w_overflow, w_stall);
    end
  endtask

  initial begin
    rst = 1; w_rst = 1; w_enable = 0; w_ev_stall = 0; w_clear = 0;
    quiet();
    test_reset();
    test_count();
    test_enable_low();
    test_finish();
    test_snapshot();
    test_rst_handshake();
    test_clear_capture();
    test_width();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
